// File: rtl/axilite_csr_read_data.sv
// AXI4-Lite read responder returning data-bus word slices of a flat CSR vector.
// Define AXILITE_CSR_READ_ADDR_BUF_EN to add a one-entry AR buffer for one read per cycle.
module axilite_csr_read_data #(
  parameter int         DATA_SIZE   = 128,
  parameter int         ADDR_SIZE   = 32,
  parameter int         DATA_WIDTH  = 32,
  parameter logic [1:0] RESP_OKAY   = 2'd0,
  parameter logic [1:0] RESP_SLVERR = 2'd2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_SIZE-1:0]  regs,
  input  logic [ADDR_SIZE-1:0]  araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int AB     = $clog2(DATA_WIDTH / 8);
  localparam int NWORDS = DATA_SIZE / DATA_WIDTH;
  localparam int WI     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [ADDR_SIZE+2:0] MAX_OFF = (ADDR_SIZE + 3)'(DATA_SIZE - DATA_WIDTH);

  typedef enum logic {IDLE, RESP} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] words [NWORDS];

  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_words
      assign words[gi] = regs[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  logic [ADDR_SIZE-1:0]  aligned;
  logic                  in_oor;
  logic [WI-1:0]         in_idx;
  logic [WI-1:0]         load_idx;
  logic                  load_oor;
  logic [DATA_WIDTH-1:0] load_data;
  logic [1:0]            load_resp;
  logic                  ar_hs;
  logic                  r_hs;

  // Bit offset is widened by three bits so huge addresses cannot wrap into range.
  assign aligned = araddr & ~ADDR_SIZE'(DATA_WIDTH / 8 - 1);
  assign in_oor  = ({3'b000, aligned} << 3) > MAX_OFF;
  assign in_idx  = WI'(aligned >> AB);
  assign ar_hs   = arvalid && arready;
  assign r_hs    = rvalid && rready;

`ifdef AXILITE_CSR_READ_ADDR_BUF_EN
  logic          buf_full;
  logic [WI-1:0] buf_idx;
  logic          buf_oor;
`endif

  // A pending buffered address always takes priority over the incoming one.
  always_comb begin
    load_idx = in_idx;
    load_oor = in_oor;
`ifdef AXILITE_CSR_READ_ADDR_BUF_EN
    if (buf_full) begin
      load_idx = buf_idx;
      load_oor = buf_oor;
    end
`endif
    load_data = load_oor ? '0 : words[load_idx];
    load_resp = load_oor ? RESP_SLVERR : RESP_OKAY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
`ifdef AXILITE_CSR_READ_ADDR_BUF_EN
      buf_full <= 1'b0;
      buf_idx  <= '0;
      buf_oor  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          arready <= 1'b1;
          if (ar_hs) begin
            state  <= RESP;
            rvalid <= 1'b1;
            rdata  <= load_data;
            rresp  <= load_resp;
`ifndef AXILITE_CSR_READ_ADDR_BUF_EN
            arready <= 1'b0;
`endif
          end
        end
        RESP: begin
`ifdef AXILITE_CSR_READ_ADDR_BUF_EN
          if (r_hs) begin
            arready <= 1'b1;
            if (buf_full || ar_hs) begin
              rdata    <= load_data;
              rresp    <= load_resp;
              buf_full <= 1'b0;
            end else begin
              state  <= IDLE;
              rvalid <= 1'b0;
            end
          end else if (ar_hs) begin
            buf_full <= 1'b1;
            buf_idx  <= in_idx;
            buf_oor  <= in_oor;
            arready  <= 1'b0;
          end
`else
          if (r_hs) begin
            state   <= IDLE;
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axilite_csr_read_data.sv
// Randomized self-checking bench for axilite_csr_read_data with a transaction-level model.
// Buffer-mode expectations follow AXILITE_CSR_READ_ADDR_BUF_EN.
module tb_axilite_csr_read_data;

  localparam int DS = 128;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [DS-1:0] BASE = 128'h44444444_33333333_22222222_11111111;
`ifdef AXILITE_CSR_READ_ADDR_BUF_EN
  localparam bit BUF_MODE = 1'b1;
`else
  localparam bit BUF_MODE = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [DS-1:0] regs;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  int checks = 0;
  int errors = 0;

  axilite_csr_read_data dut (
    .clk(clk), .rst(rst), .regs(regs), .araddr(araddr), .arvalid(arvalid),
    .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // Model: one presented beat plus a queue of accepted addresses awaiting presentation.
  bit          started;
  bit          m_valid;
  logic [31:0] m_data;
  logic [1:0]  m_resp;
  logic [31:0] pend[$];
  bit          arh, rh;

  function automatic bit m_arready();
    if (BUF_MODE) return started && (pend.size() == 0);
    return started && !m_valid;
  endfunction

  task automatic present(input logic [31:0] a);
    longint unsigned al;
    al = longint'(a) & ~longint'(DW / 8 - 1);
    m_valid = 1'b1;
    if (al * 8 > DS - DW) begin
      m_data = '0;
      m_resp = 2'd2;
    end else begin
      m_data = regs[int'(al * 8) +: DW];
      m_resp = 2'd0;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      started = 1'b0;
      m_valid = 1'b0;
      pend.delete();
    end else begin
      arh = arvalid && m_arready();
      rh  = m_valid && rready;
      if (rh) begin
        if (pend.size() > 0) present(pend.pop_front());
        else if (arh)        present(araddr);
        else                 m_valid = 1'b0;
      end else if (arh) begin
        if (!m_valid) present(araddr);
        else          pend.push_back(araddr);
      end
      started = 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("cyc_arready", arready, m_arready());
      chk("cyc_rvalid", rvalid, m_valid);
      if (m_valid) begin
        chk("cyc_rdata", rdata, m_data);
        chk("cyc_rresp", rresp, m_resp);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (arready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("arready_wait", arready, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    @(negedge clk);
    rready = 1'b1;
    wait_ready();
    arvalid = 1'b1;
    araddr  = a;
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid", rvalid, 1);
    chk("rd_rdata", rdata, ed);
    chk("rd_rresp", rresp, er);
    @(negedge clk);
    chk("rd_rvalid_drop", rvalid, 0);
    $display("read addr=%h rdata=%h rresp=%0d", a, ed, er);
  endtask

  initial begin
    rst = 1'b1; regs = BASE; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_arready", arready, 1);
    chk("rel_rvalid", rvalid, 0);
    chk("rel_rdata", rdata, 0);

    do_read(32'h4, 32'h22222222, 2'd0);
    do_read(32'h7, 32'h22222222, 2'd0);
    do_read(32'hC, 32'h44444444, 2'd0);
    do_read(32'h10, 32'h0, 2'd2);
    do_read(32'hFFFFFFFC, 32'h0, 2'd2);

    // Stalled beat must hold its data although regs changes underneath.
    @(negedge clk);
    rready = 1'b0;
    wait_ready();
    arvalid = 1'b1;
    araddr  = 32'h0;
    @(negedge clk);
    arvalid = 1'b0;
    regs[31:0] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rdata", rdata, 32'h11111111);
      if (!BUF_MODE) chk("stall_arready", arready, 0);
      if (i < 2) @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("stall_done", rvalid, 0);
    regs = BASE;
    $display("stall read addr=0 rdata=11111111");

    // Reset while a beat is pending.
    @(negedge clk);
    rready = 1'b0;
    wait_ready();
    arvalid = 1'b1;
    araddr  = 32'h4;
    @(negedge clk);
    arvalid = 1'b0;
    chk("pre_rst_rvalid", rvalid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rvalid", rvalid, 0);
    chk("async_arready", arready, 0);
    chk("async_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_rvalid", rvalid, 0);
    end
    $display("reset during RESP");

    if (BUF_MODE) begin
      @(negedge clk);
      rready = 1'b1;
      wait_ready();
      arvalid = 1'b1;
      araddr  = 32'h0;
      @(negedge clk);
      chk("b2b0_rvalid", rvalid, 1);
      chk("b2b0_rdata", rdata, 32'h11111111);
      araddr = 32'h8;
      @(negedge clk);
      chk("b2b1_rvalid", rvalid, 1);
      chk("b2b1_rdata", rdata, 32'h33333333);
      araddr = 32'hC;
      @(negedge clk);
      chk("b2b2_rvalid", rvalid, 1);
      chk("b2b2_rdata", rdata, 32'h44444444);
      arvalid = 1'b0;
      @(negedge clk);
      chk("b2b_end", rvalid, 0);
      $display("back-to-back reads 0x0 0x8 0xC");
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      arvalid = 1'($urandom_range(0, 1));
      araddr  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 23));
      rready  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 3)*32 +: 32] = $urandom();
      rst = ($urandom_range(0, 199) == 0);
      if (arvalid && m_arready() && !rst)
        $display("rand ar addr=%h", araddr);
    end
    @(negedge clk);
    rst = 1'b0;
    arvalid = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
